vital_threshold_monitor: RTL and testbench
==========================================

// Module: vital_threshold_monitor
// PURPOSE
//  Streaming window comparator for one vital-sign channel (heart rate, SpO2, temp).
//  Classifies each sample against programmable low/high limits as below/inside/above.
//  Raises a latched, debounced alarm after PERSIST consecutive out-of-range samples.
//  Clears the alarm only after CLEAR consecutive samples that sit inside the limits by a HYST margin.
//  Sits between the sensor sample front-end and the alarm/display controller.
// PARAMETERS
//  WIDTH    8  sample and limit width, unsigned
//  PERSIST  4  consecutive out-of-range samples needed to raise an alarm (>=1)
//  CLEAR    3  consecutive recovered samples needed to clear an alarm (>=1)
//  HYST     2  recovery margin, in LSBs, applied inside the violated limit
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  cfg_load   in   1      latch low_in/high_in into the limit registers
//  low_in     in   WIDTH  low limit value
//  high_in    in   WIDTH  high limit value
//  s_valid    in   1      sample strobe; one sample per asserted cycle
//  s_data     in   WIDTH  sample value
//  c_valid    out  1      registered classification strobe
//  c_lt       out  1      sample < low limit
//  c_in       out  1      low <= sample <= high
//  c_gt       out  1      sample > high limit
//  alarm_lo   out  1      latched low alarm
//  alarm_hi   out  1      latched high alarm
//  cfg_err    out  1      limits invalid (low > high)
// BEHAVIOUR
//  Reset:
//   - All outputs are 0. Limits reset to low=0, high=all-ones.
//   - Counters are 0. The FSM is in NORMAL.
//  Latency and classification:
//   - c_* and c_valid register 1 cycle after s_valid. Between samples, c_valid=0 and c_* hold their last value.
//   - Exactly one of c_lt/c_in/c_gt is 1 after the first sample.
//  Limits:
//   - cfg_load updates the limits at the next edge.
//   - cfg_err is registered: cfg_err = (low_reg > high_reg).
//   - If cfg_load and s_valid occur in the same cycle, the sample is classified against the OLD limits but is not counted.
//   - cfg_load forces the FSM to NORMAL and clears the counters and both alarms.
//  Invalid limits: while cfg_err=1, classification still runs, but the FSM is held in NORMAL with the alarms at 0.
//  Recovery thresholds, computed in WIDTH+1 bits and saturating:
//   - lo_rec = min(low + HYST, all-ones); recovered-from-low when s_data >= lo_rec.
//   - hi_rec = max(high - HYST, 0); recovered-from-high when s_data <= hi_rec.
//  Counter: cnt, width $clog2(max(PERSIST,CLEAR)+1). It changes only on counted samples.
//  FSM transitions, evaluated on counted samples only:
//   - NORMAL:
//     - lt: cnt=1 -> PEND_LO; if PERSIST==1, go straight to ALARM_LO.
//     - gt: same as lt, but to PEND_HI / ALARM_HI.
//     - in: stay, cnt=0.
//   - PEND_LO:
//     - lt: cnt+1; on reaching PERSIST -> ALARM_LO.
//     - in: -> NORMAL, cnt=0.
//     - gt: -> PEND_HI, cnt=1.
//   - PEND_HI: symmetric to PEND_LO.
//   - ALARM_LO:
//     - alarm_lo=1.
//     - Recovered-from-low sample: cnt+1; on reaching CLEAR -> NORMAL with alarm_lo=0.
//     - Any other sample: cnt=0.
//     - A gt sample: alarm_hi also begins pending; alarm_lo still requires recovery.
//   - ALARM_HI: symmetric to ALARM_LO.
//  Alarm timing:
//   - An alarm rises in the same cycle that c_valid flags the PERSIST-th sample.
//   - An alarm falls in the same cycle that c_valid flags the CLEAR-th recovered sample.
//  Both alarms may be 1 at once only via the ALARM_LO/gt path (or its mirror). The bench checks this.
//  Reset mid-operation clears everything immediately, asynchronously.
// TESTING
//  T1 reset:
//   - Assert rst_n=0 mid-stream -> all outputs are 0 immediately.
//   - After release, limits = 0/255.
//  T2 classify, with low=60, high=100:
//   - Samples 59, 60, 100, 101 -> (lt), (in), (in), (gt).
//   - Each result appears 1 cycle after its s_valid.
//  T3 persistence, PERSIST=4:
//   - Samples 55, 55, 55, 70 -> no alarm, FSM back to NORMAL.
//   - Samples 55 x4 -> alarm_lo=1 with the 4th c_valid.
//  T4 hysteresis, HYST=2, CLEAR=3:
//   - From alarm_lo: 61, 62, 62, 61, 62, 62, 62 -> alarm_lo stays 1 until the 7th sample, then 0.
//  T5 config:
//   - cfg_load with low=120, high=100 -> cfg_err=1 and alarms forced 0.
//   - Sample 50 -> c_lt=1 but no alarm ever.
//   - Same-cycle cfg_load + sample -> classified against the old limits.
//  T6 saturation:
//   - low=254, high=255, HYST=2 -> lo_rec=255.
//   - high=1 -> hi_rec=0.
//   - No wrap-around: recovery still occurs at the boundary values.

Source files
------------

// File: rtl/vital_threshold_monitor.sv
// -----------------------------------------------------------------------------
// vital_threshold_monitor
//
// Streaming window comparator for one vital-sign channel. Each sample is
// classified against programmable low/high limits as below / inside / above.
// A latched alarm is raised after PERSIST consecutive out-of-range samples on
// the same side. It is cleared after CLEAR consecutive samples that sit inside
// the limits by at least HYST LSBs away from the violated limit.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   cfg_load  in   1      load low_in/high_in into the limit registers
//   low_in    in   WIDTH  low limit
//   high_in   in   WIDTH  high limit
//   s_valid   in   1      sample strobe
//   s_data    in   WIDTH  sample value
//   c_valid   out  1      classification strobe, one cycle after s_valid
//   c_lt      out  1      sample < low
//   c_in      out  1      low <= sample <= high
//   c_gt      out  1      sample > high
//   alarm_lo  out  1      latched low alarm
//   alarm_hi  out  1      latched high alarm
//   cfg_err   out  1      loaded limits are invalid (low > high)
// -----------------------------------------------------------------------------
module vital_threshold_monitor #(
   parameter int WIDTH   = 8,
   parameter int PERSIST = 4,
   parameter int CLEAR   = 3,
   parameter int HYST    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_load,
   input  logic [WIDTH-1:0] low_in,
   input  logic [WIDTH-1:0] high_in,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             c_valid,
   output logic             c_lt,
   output logic             c_in,
   output logic             c_gt,
   output logic             alarm_lo,
   output logic             alarm_hi,
   output logic             cfg_err
);

   localparam int MAXC = (PERSIST > CLEAR) ? PERSIST : CLEAR;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] ONE_C     = CW'(1);
   localparam logic [CW-1:0] PERSIST_C = CW'(PERSIST);
   localparam logic [CW-1:0] CLEAR_C   = CW'(CLEAR);
   localparam logic [WIDTH:0] HYST_W   = (WIDTH+1)'(HYST);

   typedef enum logic [2:0] {
      NORMAL,
      PEND_LO,
      PEND_HI,
      ALARM_LO,
      ALARM_HI
   } state_t;

   // Limits and configuration status
   logic [WIDTH-1:0] low_reg, high_reg;
   logic             cfg_err_reg;

   // Classification outputs
   logic c_valid_reg, c_lt_reg, c_in_reg, c_gt_reg;

   // FSM state. cnt counts the primary run (pending or recovery). sec counts
   // a run of opposite-side violations while an alarm is held; dual marks
   // that the opposite alarm has also been latched.
   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [CW-1:0] sec_reg, sec_next;
   logic          dual_reg, dual_next;

   // Classification of the current input sample against the current limits.
   // Priority to lt keeps the three flags one-hot even when limits are invalid.
   logic is_lt, is_gt, is_in;
   assign is_lt = (s_data < low_reg);
   assign is_gt = !is_lt && (s_data > high_reg);
   assign is_in = !is_lt && !is_gt;

   // Recovery thresholds, saturating instead of wrapping at the range ends
   logic [WIDTH:0]   lo_sum, hi_dif;
   logic [WIDTH-1:0] lo_rec, hi_rec;
   assign lo_sum = {1'b0, low_reg} + HYST_W;
   assign hi_dif = {1'b0, high_reg} - HYST_W;
   assign lo_rec = lo_sum[WIDTH] ? {WIDTH{1'b1}} : lo_sum[WIDTH-1:0];
   assign hi_rec = hi_dif[WIDTH] ? {WIDTH{1'b0}} : hi_dif[WIDTH-1:0];

   logic rec_lo, rec_hi;
   assign rec_lo = is_in && (s_data >= lo_rec);
   assign rec_hi = is_in && (s_data <= hi_rec);

   logic [CW-1:0] cnt_inc, sec_inc, run_len;
   assign cnt_inc = cnt_reg + ONE_C;
   assign sec_inc = sec_reg + ONE_C;

   // -------------------------------------------------------------------------
   // Limits, config error and classification registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         low_reg     <= '0;
         high_reg    <= '1;
         cfg_err_reg <= 1'b0;
         c_valid_reg <= 1'b0;
         c_lt_reg    <= 1'b0;
         c_in_reg    <= 1'b0;
         c_gt_reg    <= 1'b0;
      end else begin
         if (cfg_load) begin
            low_reg     <= low_in;
            high_reg    <= high_in;
            // Registered alongside the limits so it always describes them
            cfg_err_reg <= (low_in > high_in);
         end
         c_valid_reg <= s_valid;
         if (s_valid) begin
            c_lt_reg <= is_lt;
            c_in_reg <= is_in;
            c_gt_reg <= is_gt;
         end
      end
   end

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= NORMAL;
         cnt_reg   <= '0;
         sec_reg   <= '0;
         dual_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         sec_reg   <= sec_next;
         dual_reg  <= dual_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sec_next   = sec_reg;
      dual_next  = dual_reg;
      run_len    = ONE_C;

      if (cfg_load || cfg_err_reg) begin
         // A reconfiguration (or invalid limits) restarts supervision
         state_next = NORMAL;
         cnt_next   = '0;
         sec_next   = '0;
         dual_next  = 1'b0;
      end else if (s_valid) begin
         case (state_reg)
            NORMAL, PEND_LO, PEND_HI: begin
               if (is_lt) begin
                  run_len = (state_reg == PEND_LO) ? cnt_inc : ONE_C;
                  if (run_len == PERSIST_C) begin
                     state_next = ALARM_LO;
                     cnt_next   = '0;
                  end else begin
                     state_next = PEND_LO;
                     cnt_next   = run_len;
                  end
               end else if (is_gt) begin
                  run_len = (state_reg == PEND_HI) ? cnt_inc : ONE_C;
                  if (run_len == PERSIST_C) begin
                     state_next = ALARM_HI;
                     cnt_next   = '0;
                  end else begin
                     state_next = PEND_HI;
                     cnt_next   = run_len;
                  end
               end else begin
                  state_next = NORMAL;
                  cnt_next   = '0;
               end
               sec_next  = '0;
               dual_next = 1'b0;
            end

            ALARM_LO: begin
               // Track a high-side run while the low alarm is held
               if (!dual_reg) begin
                  if (is_gt) begin
                     if (sec_inc == PERSIST_C) begin
                        dual_next = 1'b1;
                        sec_next  = '0;
                     end else begin
                        sec_next = sec_inc;
                     end
                  end else begin
                     sec_next = '0;
                  end
               end
               if (rec_lo) begin
                  if (cnt_inc == CLEAR_C) begin
                     // Low alarm released; a latched high alarm carries over
                     state_next = dual_reg ? ALARM_HI : NORMAL;
                     cnt_next   = '0;
                     sec_next   = '0;
                     dual_next  = 1'b0;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end else begin
                  cnt_next = '0;
               end
            end

            ALARM_HI: begin
               if (!dual_reg) begin
                  if (is_lt) begin
                     if (sec_inc == PERSIST_C) begin
                        dual_next = 1'b1;
                        sec_next  = '0;
                     end else begin
                        sec_next = sec_inc;
                     end
                  end else begin
                     sec_next = '0;
                  end
               end
               if (rec_hi) begin
                  if (cnt_inc == CLEAR_C) begin
                     state_next = dual_reg ? ALARM_LO : NORMAL;
                     cnt_next   = '0;
                     sec_next   = '0;
                     dual_next  = 1'b0;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end else begin
                  cnt_next = '0;
               end
            end

            default: begin
               state_next = NORMAL;
               cnt_next   = '0;
               sec_next   = '0;
               dual_next  = 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign c_valid  = c_valid_reg;
   assign c_lt     = c_lt_reg;
   assign c_in     = c_in_reg;
   assign c_gt     = c_gt_reg;
   assign cfg_err  = cfg_err_reg;
   assign alarm_lo = (state_reg == ALARM_LO) || ((state_reg == ALARM_HI) && dual_reg);
   assign alarm_hi = (state_reg == ALARM_HI) || ((state_reg == ALARM_LO) && dual_reg);

endmodule

// File: tb/tb_vital_threshold_monitor.sv
// -----------------------------------------------------------------------------
// tb_vital_threshold_monitor
//
// Directed, table-driven bench. Each table row is one clock cycle of input
// stimulus plus the output vector expected just after that edge:
// {c_valid, c_lt, c_in, c_gt, alarm_lo, alarm_hi, cfg_err}.
// -----------------------------------------------------------------------------
module tb_vital_threshold_monitor;

   localparam int NONE = 0;
   localparam int LT   = 1;
   localparam int IN   = 2;
   localparam int GT   = 3;

   logic       clk;
   logic       rst_n;
   logic       cfg_load;
   logic [7:0] low_in, high_in;
   logic       s_valid;
   logic [7:0] s_data;
   logic       c_valid, c_lt, c_in, c_gt, alarm_lo, alarm_hi, cfg_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       cl;
      logic [7:0] lo;
      logic [7:0] hi;
      logic       sv;
      logic [7:0] sd;
      logic [6:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   vital_threshold_monitor #(
      .WIDTH(8), .PERSIST(4), .CLEAR(3), .HYST(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
      .low_in(low_in), .high_in(high_in),
      .s_valid(s_valid), .s_data(s_data),
      .c_valid(c_valid), .c_lt(c_lt), .c_in(c_in), .c_gt(c_gt),
      .alarm_lo(alarm_lo), .alarm_hi(alarm_hi), .cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] mk(input logic ev, input int cls,
                                     input logic alo, input logic ahi, input logic err);
      return {ev, cls == LT, cls == IN, cls == GT, alo, ahi, err};
   endfunction

   task automatic push(input logic cl, input logic [7:0] lo, input logic [7:0] hi,
                       input logic sv, input logic [7:0] sd, input logic [6:0] e,
                       input string nm);
      vec_t v;
      v.cl = cl; v.lo = lo; v.hi = hi; v.sv = sv; v.sd = sd; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic smp(input string nm, input logic [7:0] d, input int cls,
                      input logic alo, input logic ahi, input logic err);
      push(1'b0, 8'd0, 8'd0, 1'b1, d, mk(1'b1, cls, alo, ahi, err), nm);
   endtask

   task automatic idl(input string nm, input int cls, input logic alo,
                      input logic ahi, input logic err);
      push(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, mk(1'b0, cls, alo, ahi, err), nm);
   endtask

   task automatic cfg(input string nm, input logic [7:0] lo, input logic [7:0] hi,
                      input int cls, input logic err);
      push(1'b1, lo, hi, 1'b0, 8'd0, mk(1'b0, cls, 1'b0, 1'b0, err), nm);
   endtask

   task automatic cfgs(input string nm, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] d, input int cls, input logic err);
      push(1'b1, lo, hi, 1'b1, d, mk(1'b1, cls, 1'b0, 1'b0, err), nm);
   endtask

   task automatic check(input string nm, input logic [6:0] exp);
      logic [6:0] got;
      got = {c_valid, c_lt, c_in, c_gt, alarm_lo, alarm_hi, cfg_err};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b expected=%b", nm, got, exp);
      end
   endtask

   task automatic run_queue();
      foreach (vecs[i]) begin
         @(negedge clk);
         cfg_load = vecs[i].cl;
         low_in   = vecs[i].lo;
         high_in  = vecs[i].hi;
         s_valid  = vecs[i].sv;
         s_data   = vecs[i].sd;
         @(posedge clk);
         #1;
         $display("vec %s cl=%0d lo=%0d hi=%0d sv=%0d sd=%0d out=%b exp=%b",
                  vecs[i].name, vecs[i].cl, vecs[i].lo, vecs[i].hi, vecs[i].sv,
                  vecs[i].sd, {c_valid, c_lt, c_in, c_gt, alarm_lo, alarm_hi, cfg_err},
                  vecs[i].exp);
         check(vecs[i].name, vecs[i].exp);
      end
      vecs.delete();
      @(negedge clk);
      cfg_load = 1'b0;
      s_valid  = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      cfg_load = 1'b0;
      low_in   = 8'd0;
      high_in  = 8'd0;
      s_valid  = 1'b0;
      s_data   = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 7'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state and default limits 0/255
      idl("idle_after_reset", NONE, 0, 0, 0);
      smp("dflt_0", 8'd0, IN, 0, 0, 0);
      smp("dflt_255", 8'd255, IN, 0, 0, 0);

      // Classification with low=60, high=100
      cfg("cfg_60_100", 8'd60, 8'd100, IN, 0);
      smp("cls_59", 8'd59, LT, 0, 0, 0);
      smp("cls_60", 8'd60, IN, 0, 0, 0);
      smp("cls_100", 8'd100, IN, 0, 0, 0);
      smp("cls_101", 8'd101, GT, 0, 0, 0);
      idl("cls_hold", GT, 0, 0, 0);

      // Persistence: broken run, then a full run of four
      smp("pers_a1", 8'd55, LT, 0, 0, 0);
      smp("pers_a2", 8'd55, LT, 0, 0, 0);
      smp("pers_a3", 8'd55, LT, 0, 0, 0);
      smp("pers_a4_in", 8'd70, IN, 0, 0, 0);
      smp("pers_b1", 8'd55, LT, 0, 0, 0);
      smp("pers_b2", 8'd55, LT, 0, 0, 0);
      smp("pers_b3", 8'd55, LT, 0, 0, 0);
      smp("pers_b4_alarm", 8'd55, LT, 1, 0, 0);

      // Hysteresis: lo_rec = 62
      smp("hyst_61", 8'd61, IN, 1, 0, 0);
      smp("hyst_62a", 8'd62, IN, 1, 0, 0);
      smp("hyst_62b", 8'd62, IN, 1, 0, 0);
      smp("hyst_61_break", 8'd61, IN, 1, 0, 0);
      smp("hyst_62c", 8'd62, IN, 1, 0, 0);
      smp("hyst_62d", 8'd62, IN, 1, 0, 0);
      smp("hyst_62e_clear", 8'd62, IN, 0, 0, 0);

      // Dual alarm via ALARM_LO then a high run, then staged recovery
      smp("dual_lo1", 8'd55, LT, 0, 0, 0);
      smp("dual_lo2", 8'd55, LT, 0, 0, 0);
      smp("dual_lo3", 8'd55, LT, 0, 0, 0);
      smp("dual_lo4", 8'd55, LT, 1, 0, 0);
      smp("dual_hi1", 8'd110, GT, 1, 0, 0);
      smp("dual_hi2", 8'd110, GT, 1, 0, 0);
      smp("dual_hi3", 8'd110, GT, 1, 0, 0);
      smp("dual_hi4_both", 8'd110, GT, 1, 1, 0);
      smp("dual_rec1", 8'd80, IN, 1, 1, 0);
      smp("dual_rec2", 8'd80, IN, 1, 1, 0);
      smp("dual_rec3_lo_off", 8'd80, IN, 0, 1, 0);
      smp("dual_rec4", 8'd80, IN, 0, 1, 0);
      smp("dual_rec5", 8'd80, IN, 0, 1, 0);
      smp("dual_rec6_hi_off", 8'd80, IN, 0, 0, 0);

      // Config: invalid limits force alarms off; same-cycle load uses old limits
      smp("cfg_lo1", 8'd55, LT, 0, 0, 0);
      smp("cfg_lo2", 8'd55, LT, 0, 0, 0);
      smp("cfg_lo3", 8'd55, LT, 0, 0, 0);
      smp("cfg_lo4", 8'd55, LT, 1, 0, 0);
      cfg("cfg_bad", 8'd120, 8'd100, LT, 1);
      smp("bad_50a", 8'd50, LT, 0, 0, 1);
      smp("bad_50b", 8'd50, LT, 0, 0, 1);
      smp("bad_50c", 8'd50, LT, 0, 0, 1);
      smp("bad_50d", 8'd50, LT, 0, 0, 1);
      smp("bad_50e", 8'd50, LT, 0, 0, 1);
      cfg("cfg_restore", 8'd60, 8'd100, LT, 0);
      cfgs("cfg_same_cycle", 8'd0, 8'd50, 8'd70, IN, 0);
      smp("new_gt1", 8'd70, GT, 0, 0, 0);
      smp("new_gt2", 8'd70, GT, 0, 0, 0);
      smp("new_gt3", 8'd70, GT, 0, 0, 0);
      smp("new_gt4_alarm", 8'd70, GT, 0, 1, 0);

      // Saturation: low=254 -> lo_rec=255
      cfg("cfg_254_255", 8'd254, 8'd255, GT, 0);
      smp("sat_lo1", 8'd0, LT, 0, 0, 0);
      smp("sat_lo2", 8'd0, LT, 0, 0, 0);
      smp("sat_lo3", 8'd0, LT, 0, 0, 0);
      smp("sat_lo4", 8'd0, LT, 1, 0, 0);
      smp("sat_255a", 8'd255, IN, 1, 0, 0);
      smp("sat_255b", 8'd255, IN, 1, 0, 0);
      smp("sat_254_break", 8'd254, IN, 1, 0, 0);
      smp("sat_255c", 8'd255, IN, 1, 0, 0);
      smp("sat_255d", 8'd255, IN, 1, 0, 0);
      smp("sat_255e_clear", 8'd255, IN, 0, 0, 0);

      // Saturation: high=1 -> hi_rec=0
      cfg("cfg_0_1", 8'd0, 8'd1, IN, 0);
      smp("sat_hi1", 8'd5, GT, 0, 0, 0);
      smp("sat_hi2", 8'd5, GT, 0, 0, 0);
      smp("sat_hi3", 8'd5, GT, 0, 0, 0);
      smp("sat_hi4", 8'd5, GT, 0, 1, 0);
      smp("sat_1_norec", 8'd1, IN, 0, 1, 0);
      smp("sat_0a", 8'd0, IN, 0, 1, 0);
      smp("sat_0b", 8'd0, IN, 0, 1, 0);
      smp("sat_0c_clear", 8'd0, IN, 0, 0, 0);

      // Build up an alarm before the mid-stream reset
      cfg("pre_rst_cfg", 8'd60, 8'd100, IN, 0);
      smp("pre_rst1", 8'd55, LT, 0, 0, 0);
      smp("pre_rst2", 8'd55, LT, 0, 0, 0);
      smp("pre_rst3", 8'd55, LT, 0, 0, 0);
      smp("pre_rst4", 8'd55, LT, 1, 0, 0);
      run_queue();

      // Asynchronous reset mid-stream, between clock edges
      s_valid = 1'b1;
      s_data  = 8'd55;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", 7'b0);
      @(posedge clk);
      #1;
      check("async_reset_held", 7'b0);
      @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b1;

      // Limits returned to 0/255: extremes are inside, 55 no longer low
      smp("post_rst_0", 8'd0, IN, 0, 0, 0);
      smp("post_rst_55", 8'd55, IN, 0, 0, 0);
      smp("post_rst_255", 8'd255, IN, 0, 0, 0);
      run_queue();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
